pipeline_processor: RTL and testbench

16-bit, five-stage (IF, ID, EX, MEM, WB) pipelined processor core with internal instruction and data memories, one input port, one output port and a single external interrupt with acknowledge. It is the top of the processor design. The testbench drives only clock, reset, `portIn` and `int`, and observes `portOut` and `ack`.

---
 rtl/processor_pkg.sv | 76 +++++++
 rtl/pipeline_processor_alu.sv | 35 +++
 rtl/pipeline_processor.sv | 165 ++++++++++++++++
 tb/tb_pipeline_processor.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared opcodes, pipeline-register layouts and decode helpers for the
// five-stage 16-bit pipeline_processor core.
package processor_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LDD = 4'h9;
  localparam logic [3:0] OP_STD = 4'hA;
  localparam logic [3:0] OP_IN  = 4'hB;
  localparam logic [3:0] OP_OUT = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_RTI = 4'hF;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

  typedef struct packed {
    logic [15:0] instr;
  } ifId_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [7:0]  imm;
    logic [15:0] rsVal;
    logic [15:0] rtVal;
    logic        wrEn;
  } idEx_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] result;
    logic [15:0] storeData;
    logic        wrEn;
  } exMem_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] result;
    logic        wrEn;
  } memWb_t;

  function automatic logic writesReg(input logic [3:0] op);
    return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
                      OP_INC, OP_LDI, OP_LDD, OP_IN};
  endfunction

  function automatic logic readsRs(input logic [3:0] op);
    return op inside {OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
                      OP_INC, OP_LDD, OP_STD, OP_OUT, OP_JZ, OP_JMP};
  endfunction

  function automatic logic readsRt(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STD};
  endfunction

  function automatic logic isControl(input logic [3:0] op);
    return op inside {OP_JZ, OP_JMP, OP_RTI};
  endfunction

endpackage

// File: rtl/pipeline_processor_alu.sv
// 16-bit ALU for the EX stage; reports Z/N/C and whether the opcode updates flags.
module alu
  import processor_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o,
  output flags_t      flags_o,
  output logic        flagWe_o
);

  logic [16:0] wide;

  // Bit 16 carries the carry (ADD/INC) or borrow (SUB); logic ops leave it zero.
  always_comb begin
    wide     = {1'b0, a_i};
    flagWe_o = 1'b0;
    case (op_i)
      OP_ADD: begin wide = {1'b0, a_i} + {1'b0, b_i}; flagWe_o = 1'b1; end
      OP_SUB: begin wide = {1'b0, a_i} - {1'b0, b_i}; flagWe_o = 1'b1; end
      OP_AND: begin wide = {1'b0, a_i & b_i};         flagWe_o = 1'b1; end
      OP_OR:  begin wide = {1'b0, a_i | b_i};         flagWe_o = 1'b1; end
      OP_NOT: begin wide = {1'b0, ~a_i};              flagWe_o = 1'b1; end
      OP_INC: begin wide = {1'b0, a_i} + 17'd1;       flagWe_o = 1'b1; end
      OP_LDI: wide = {1'b0, b_i};
      default: wide = {1'b0, a_i};
    endcase
    y_o       = wide[15:0];
    flags_o.z = (wide[15:0] == 16'h0000);
    flags_o.n = wide[15];
    flags_o.c = wide[16];
  end

endmodule

// File: rtl/pipeline_processor.sv
// Five-stage pipelined 16-bit core with forwarding, load-use stall, EX-resolved
// branches and a single edge-triggered interrupt with return via RTI.
module pipeline_processor
  import processor_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "imem.hex",
  parameter int          DMEM_DEPTH = 256,
  parameter logic [15:0] INT_VECTOR = 16'h0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] portIn,
  input  logic        int_i,
  output logic [15:0] portOut,
  output logic        ack
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [15:0] imem [IMEM_DEPTH];
  logic [15:0] dmem [DMEM_DEPTH];

  logic [15:0] pc_q, pc_d, epc_q, epc_d, portOut_q;
  logic [15:0] regs_q [8];
  ifId_t       ifId_q, ifId_d;
  idEx_t       idEx_q, idEx_d;
  exMem_t      exMem_q, exMem_d;
  memWb_t      memWb_q, memWb_d;
  flags_t      flags_q, flags_d, aluFlags;
  logic        pending_q, pending_d, isr_q, isr_d, intPrev_q, ack_q;

  logic [3:0]  idOp;
  logic [2:0]  idRs, idRt;
  logic [15:0] exA, exB, aluB, aluY, exResult, target;
  logic        aluFlagWe, stall, takeBranch, takeInt;

  assign idOp = ifId_q.instr[15:12];
  assign idRs = ifId_q.instr[8:6];
  assign idRt = ifId_q.instr[5:3];

  // EX/MEM wins over MEM/WB so the youngest producer supplies the operand.
  always_comb begin
    exA = idEx_q.rsVal;
    exB = idEx_q.rtVal;
    if (exMem_q.wrEn && exMem_q.rd == idEx_q.rs)      exA = exMem_q.result;
    else if (memWb_q.wrEn && memWb_q.rd == idEx_q.rs) exA = memWb_q.result;
    if (exMem_q.wrEn && exMem_q.rd == idEx_q.rt)      exB = exMem_q.result;
    else if (memWb_q.wrEn && memWb_q.rd == idEx_q.rt) exB = memWb_q.result;
  end

  assign aluB = (idEx_q.op == OP_LDI) ? {8'h00, idEx_q.imm} : exB;

  alu u_alu (
    .op_i    (idEx_q.op),
    .a_i     (exA),
    .b_i     (aluB),
    .y_o     (aluY),
    .flags_o (aluFlags),
    .flagWe_o(aluFlagWe)
  );

  assign exResult   = (idEx_q.op == OP_IN) ? portIn : aluY;
  assign takeBranch = (idEx_q.op == OP_JMP) || (idEx_q.op == OP_RTI) ||
                      (idEx_q.op == OP_JZ && flags_q.z);
  assign target     = (idEx_q.op == OP_RTI) ? epc_q : exA;

  assign stall = (idEx_q.op == OP_LDD) && idEx_q.wrEn &&
                 ((readsRs(idOp) && idEx_q.rd == idRs) ||
                  (readsRt(idOp) && idEx_q.rd == idRt));

  assign takeInt = pending_q && !isr_q && !stall &&
                   !isControl(idOp) && !isControl(idEx_q.op);

  // Next-state: decode with WB bypass, then redirect / interrupt / stall overrides.
  always_comb begin
    pc_d         = pc_q + 16'd1;
    epc_d        = epc_q;
    isr_d        = isr_q;
    ifId_d.instr = imem[pc_q[IAW-1:0]];

    idEx_d.op    = idOp;
    idEx_d.rd    = ifId_q.instr[11:9];
    idEx_d.rs    = idRs;
    idEx_d.rt    = idRt;
    idEx_d.imm   = ifId_q.instr[7:0];
    idEx_d.rsVal = (memWb_q.wrEn && memWb_q.rd == idRs) ? memWb_q.result : regs_q[idRs];
    idEx_d.rtVal = (memWb_q.wrEn && memWb_q.rd == idRt) ? memWb_q.result : regs_q[idRt];
    idEx_d.wrEn  = writesReg(idOp);

    if (takeBranch) begin
      pc_d   = target;
      ifId_d = '0;
      idEx_d = '0;
      if (idEx_q.op == OP_RTI) isr_d = 1'b0;
    end else if (takeInt) begin
      pc_d   = INT_VECTOR;
      epc_d  = pc_q;
      ifId_d = '0;
      isr_d  = 1'b1;
    end else if (stall) begin
      pc_d   = pc_q;
      ifId_d = ifId_q;
      idEx_d = '0;
    end

    flags_d = aluFlagWe ? aluFlags : flags_q;

    exMem_d.op        = idEx_q.op;
    exMem_d.rd        = idEx_q.rd;
    exMem_d.result    = exResult;
    exMem_d.storeData = exB;
    exMem_d.wrEn      = idEx_q.wrEn;

    memWb_d.op     = exMem_q.op;
    memWb_d.rd     = exMem_q.rd;
    memWb_d.result = (exMem_q.op == OP_LDD) ? dmem[exMem_q.result[DAW-1:0]] : exMem_q.result;
    memWb_d.wrEn   = exMem_q.wrEn;

    pending_d = (pending_q && !takeInt) || (int_i && !intPrev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      epc_q     <= '0;
      ifId_q    <= '0;
      idEx_q    <= '0;
      exMem_q   <= '0;
      memWb_q   <= '0;
      flags_q   <= '0;
      pending_q <= 1'b0;
      isr_q     <= 1'b0;
      intPrev_q <= 1'b0;
      portOut_q <= '0;
      ack_q     <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      ifId_q    <= ifId_d;
      idEx_q    <= idEx_d;
      exMem_q   <= exMem_d;
      memWb_q   <= memWb_d;
      flags_q   <= flags_d;
      pending_q <= pending_d;
      isr_q     <= isr_d;
      intPrev_q <= int_i;
      ack_q     <= takeInt;
      if (memWb_q.wrEn) regs_q[memWb_q.rd] <= memWb_q.result;
      if (memWb_q.op == OP_OUT) portOut_q <= memWb_q.result;
    end
  end

  // A store caught in MEM when reset hits is discarded like any other in-flight op.
  always_ff @(posedge clk) begin
    if (!reset && exMem_q.op == OP_STD)
      dmem[exMem_q.result[DAW-1:0]] <= exMem_q.storeData;
  end

  assign portOut = portOut_q;
  assign ack     = ack_q;

endmodule

// File: tb/tb_pipeline_processor.sv
// Directed bench for pipeline_processor: programs are written straight into the
// instruction memory while reset is held, then outputs are checked per edge.
module tb_pipeline_processor;
  import processor_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] portIn = 16'h0000;
  logic        intLine = 1'b0;
  logic [15:0] portOut;
  logic        ack;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_processor #(.IMEM_FILE("")) dut (
    .clk    (clk),
    .reset  (reset),
    .portIn (portIn),
    .int_i  (intLine),
    .portOut(portOut),
    .ack    (ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {OP_LDI, rd, 1'b0, imm};
  endfunction

  task automatic put(input logic [7:0] addr, input logic [15:0] word);
    dut.imem[addr] = word;
  endtask

  // Hold reset for two edges and wipe the program store to NOPs.
  task automatic holdResetAndClear();
    reset = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 256; i++) put(8'(i), 16'h0000);
  endtask

  task automatic loadInterruptProgram();
    put(8'd0, ldi(3'd7, 8'd15));
    put(8'd1, ldi(3'd1, 8'd0));
    for (int k = 0; k < 6; k++) begin
      put(8'(2 + 2 * k), enc(OP_INC, 3'd1, 3'd1, 3'd0));
      put(8'(3 + 2 * k), enc(OP_OUT, 3'd0, 3'd1, 3'd0));
    end
    put(8'd15, enc(OP_JMP, 3'd0, 3'd7, 3'd0));
    put(8'd16, ldi(3'd5, 8'hAA));
    put(8'd17, enc(OP_OUT, 3'd0, 3'd5, 3'd0));
    put(8'd18, enc(OP_RTI, 3'd0, 3'd0, 3'd0));
  endtask

  task automatic test_reset();
    portIn = 16'h00DA;
    reset  = 1'b1;
    tick();
    compared++;
    if (portOut !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL reset_portOut: got %h want %h", portOut, 16'h0000);
    end
    compared++;
    if (ack !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_ack: got %b want 0", ack);
    end
    holdResetAndClear();
    put(8'd0, enc(OP_IN,  3'd1, 3'd0, 3'd0));
    put(8'd1, enc(OP_OUT, 3'd0, 3'd1, 3'd0));
    reset = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      compared++;
      if (ack !== 1'b0) begin
        mismatched++; $display("[TB] FAIL port_ack_e%0d: got %b want 0", e, ack);
      end
      if (e == 4) begin
        compared++;
        if (portOut !== 16'h0000) begin
          mismatched++; $display("[TB] FAIL port_early_e4: got %h want %h", portOut, 16'h0000);
        end
      end
      if (e == 5 || e == 8) begin
        compared++;
        if (portOut !== 16'h00DA) begin
          mismatched++; $display("[TB] FAIL port_in_out_e%0d: got %h want %h", e, portOut, 16'h00DA);
        end
      end
    end
    reset = 1'b1;
    tick();
    compared++;
    if (portOut !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL reassert_portOut: got %h want %h", portOut, 16'h0000);
    end
  endtask

  task automatic test_forwarding();
    holdResetAndClear();
    put(8'd0, ldi(3'd1, 8'd5));
    put(8'd1, ldi(3'd2, 8'd3));
    put(8'd2, enc(OP_ADD, 3'd3, 3'd1, 3'd2));
    put(8'd3, enc(OP_OUT, 3'd0, 3'd3, 3'd0));
    reset = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        compared++;
        if (portOut !== 16'h0000) begin
          mismatched++; $display("[TB] FAIL fwd_early_e6: got %h want %h", portOut, 16'h0000);
        end
      end
    end
    compared++;
    if (portOut !== 16'h0008) begin
      mismatched++; $display("[TB] FAIL fwd_add: got %h want %h", portOut, 16'h0008);
    end
  endtask

  task automatic test_load_use();
    holdResetAndClear();
    put(8'd0, ldi(3'd1, 8'd7));
    put(8'd1, ldi(3'd2, 8'd9));
    put(8'd2, enc(OP_STD, 3'd0, 3'd1, 3'd2));
    put(8'd3, enc(OP_LDD, 3'd3, 3'd1, 3'd0));
    put(8'd4, enc(OP_INC, 3'd4, 3'd3, 3'd0));
    put(8'd5, enc(OP_OUT, 3'd0, 3'd4, 3'd0));
    reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 9) begin
        compared++;
        if (portOut !== 16'h0000) begin
          mismatched++; $display("[TB] FAIL loaduse_stall_e9: got %h want %h", portOut, 16'h0000);
        end
      end
    end
    compared++;
    if (portOut !== 16'h000A) begin
      mismatched++; $display("[TB] FAIL loaduse_value_e10: got %h want %h", portOut, 16'h000A);
    end
  endtask

  task automatic test_branch_taken();
    holdResetAndClear();
    put(8'd0, ldi(3'd1, 8'd4));
    put(8'd1, enc(OP_SUB, 3'd2, 3'd1, 3'd1));
    put(8'd2, enc(OP_JZ,  3'd0, 3'd1, 3'd0));
    put(8'd3, enc(OP_OUT, 3'd0, 3'd1, 3'd0));
    put(8'd4, enc(OP_OUT, 3'd0, 3'd2, 3'd0));
    put(8'd5, ldi(3'd6, 8'h33));
    put(8'd6, enc(OP_OUT, 3'd0, 3'd6, 3'd0));
    reset = 1'b0;
    for (int e = 0; e <= 11; e++) begin
      tick();
      compared++;
      if (portOut === 16'h0004) begin
        mismatched++; $display("[TB] FAIL jz_flushed_out_e%0d: got %h want not 0004", e, portOut);
      end
      if (e == 10) begin
        compared++;
        if (portOut !== 16'h0000) begin
          mismatched++; $display("[TB] FAIL jz_penalty_e10: got %h want %h", portOut, 16'h0000);
        end
      end
    end
    compared++;
    if (portOut !== 16'h0033) begin
      mismatched++; $display("[TB] FAIL jz_taken_path_e11: got %h want %h", portOut, 16'h0033);
    end
  endtask

  task automatic test_branch_not_taken();
    holdResetAndClear();
    put(8'd0, ldi(3'd1, 8'd4));
    put(8'd1, enc(OP_SUB, 3'd2, 3'd1, 3'd0));
    put(8'd2, enc(OP_JZ,  3'd0, 3'd1, 3'd0));
    put(8'd3, enc(OP_OUT, 3'd0, 3'd1, 3'd0));
    put(8'd4, enc(OP_OUT, 3'd0, 3'd2, 3'd0));
    put(8'd5, ldi(3'd6, 8'h33));
    put(8'd6, enc(OP_OUT, 3'd0, 3'd6, 3'd0));
    reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      if (e == 7 || e == 9) begin
        compared++;
        if (portOut !== 16'h0004) begin
          mismatched++; $display("[TB] FAIL jz_fall_e%0d: got %h want %h", e, portOut, 16'h0004);
        end
      end
    end
    compared++;
    if (portOut !== 16'h0033) begin
      mismatched++; $display("[TB] FAIL jz_nopenalty_e10: got %h want %h", portOut, 16'h0033);
    end
  endtask

  task automatic test_interrupt();
    logic [15:0] seen[$];
    logic [15:0] expSeq [7];
    logic [15:0] prevOut;
    int          ackCycles;
    int          ackEdge;
    expSeq    = '{16'h0001, 16'h00AA, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
    prevOut   = 16'h0000;
    ackCycles = 0;
    ackEdge   = -1;
    holdResetAndClear();
    loadInterruptProgram();
    reset = 1'b0;
    for (int e = 0; e <= 40; e++) begin
      tick();
      if (ack === 1'b1) begin
        ackCycles++;
        if (ackEdge < 0) ackEdge = e;
      end
      if (portOut !== prevOut) begin
        seen.push_back(portOut);
        prevOut = portOut;
      end
      if (e == 3) intLine = 1'b1;
      if (e == 5) intLine = 1'b0;
    end
    compared++;
    if (ackCycles != 1) begin
      mismatched++; $display("[TB] FAIL int_ack_width: got %0d cycles want 1", ackCycles);
    end
    compared++;
    if (ackEdge != 5) begin
      mismatched++; $display("[TB] FAIL int_ack_edge: got %0d want 5", ackEdge);
    end
    compared++;
    if (seen.size() != 7) begin
      mismatched++; $display("[TB] FAIL int_out_count: got %0d want 7", seen.size());
    end
    for (int i = 0; i < 7; i++) begin
      if (i < seen.size()) begin
        compared++;
        if (seen[i] !== expSeq[i]) begin
          mismatched++; $display("[TB] FAIL int_out_seq[%0d]: got %h want %h", i, seen[i], expSeq[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_isr();
    holdResetAndClear();
    loadInterruptProgram();
    reset = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      if (e == 3) intLine = 1'b1;
      if (e == 5) intLine = 1'b0;
    end
    reset = 1'b1;
    tick();
    compared++;
    if (ack !== 1'b0) begin
      mismatched++; $display("[TB] FAIL midreset_ack: got %b want 0", ack);
    end
    compared++;
    if (portOut !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL midreset_portOut: got %h want %h", portOut, 16'h0000);
    end
    reset = 1'b0;
    for (int e = 0; e <= 30; e++) begin
      tick();
      compared++;
      if (ack !== 1'b0 || portOut === 16'h00AA) begin
        mismatched++; $display("[TB] FAIL restart_no_isr_e%0d: ack=%b portOut=%h want ack 0, no 00aa", e, ack, portOut);
      end
      if (e == 6) begin
        compared++;
        if (portOut !== 16'h0000) begin
          mismatched++; $display("[TB] FAIL restart_e6: got %h want %h", portOut, 16'h0000);
        end
      end
      if (e == 7) begin
        compared++;
        if (portOut !== 16'h0001) begin
          mismatched++; $display("[TB] FAIL restart_from0_e7: got %h want %h", portOut, 16'h0001);
        end
      end
    end
    compared++;
    if (portOut !== 16'h0006) begin
      mismatched++; $display("[TB] FAIL restart_final: got %h want %h", portOut, 16'h0006);
    end
  endtask

  initial begin
    $display("[TB] starting pipeline_processor bench");
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_interrupt();
    test_reset_mid_isr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
